// File: rtl/mul_sched_pkg.sv
// Shared types and default sizing for the multiplier scheduler.
package mul_sched_pkg;
  localparam int DEF_NREQ  = 4;
  localparam int DEF_WIDTH = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_RESP
  } state_t;
endpackage

// File: rtl/mul_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or after the pointer wins.
module mul_rr_arbiter
  import mul_sched_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  input  logic            i_en,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDW-1:0]  o_idx
);

  always_comb begin
    logic w_found;
    int   w_pos;
    o_gnt   = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = (int'(i_ptr) + k) % NREQ;
      if (i_en && !w_found && i_req[w_pos]) begin
        w_found      = 1'b1;
        o_gnt[w_pos] = 1'b1;
        o_idx        = IDW'(w_pos);
      end
    end
  end

endmodule

// File: rtl/mul_scheduler.sv
// Round-robin scheduler sharing one start/done multiplier core among NREQ requesters.
// MUL_SCHED_ZERO_BYPASS_EN: zero operands skip the core and respond with 0.
module mul_scheduler
  import mul_sched_pkg::*;
#(
  parameter int NREQ  = DEF_NREQ,
  parameter int WIDTH = DEF_WIDTH,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         i_req_valid,
  output logic [NREQ-1:0]         o_req_ready,
  input  logic [NREQ*WIDTH-1:0]   i_req_a,
  input  logic [NREQ*WIDTH-1:0]   i_req_b,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [IDW-1:0]          o_resp_id,
  output logic [2*WIDTH-1:0]      o_resp_result,
  output logic                    o_mul_start,
  output logic [WIDTH-1:0]        o_mul_multiplier,
  output logic [WIDTH-1:0]        o_mul_multiplicand,
  input  logic [2*WIDTH-1:0]      i_mul_result,
  input  logic                    i_mul_done,
  output logic                    o_busy
);

  state_t               r_state, w_next;
  logic [IDW-1:0]       r_ptr, r_id, w_idx, w_ptr_nxt;
  logic [NREQ-1:0]      w_gnt;
  logic                 w_en, w_accept, w_zero;
  logic [WIDTH-1:0]     w_a, w_b, r_a, r_b;
  logic [2*WIDTH-1:0]   r_result;

  // Reset gates the grant so req_ready reads 0 while reset is held.
  assign w_en      = (r_state == S_IDLE) && i_mul_done && !reset;
  assign w_accept  = |w_gnt;
  assign w_a       = i_req_a[w_idx*WIDTH +: WIDTH];
  assign w_b       = i_req_b[w_idx*WIDTH +: WIDTH];
  assign w_ptr_nxt = (w_idx == IDW'(NREQ-1)) ? '0 : w_idx + 1'b1;

`ifdef MUL_SCHED_ZERO_BYPASS_EN
  assign w_zero = (w_a == '0) || (w_b == '0);
`else
  assign w_zero = 1'b0;
`endif

  mul_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .i_req (i_req_valid),
    .i_ptr (r_ptr),
    .i_en  (w_en),
    .o_gnt (w_gnt),
    .o_idx (w_idx)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_mul_start  = 1'b0;
    o_resp_valid = 1'b0;
    o_busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        o_busy = 1'b0;
        if (w_accept) w_next = w_zero ? S_RESP : S_ISSUE;
      end
      S_ISSUE: begin
        o_mul_start = 1'b1;
        w_next      = S_WAIT_BUSY;
      end
      // Core must drop done before its next rising done means our result.
      S_WAIT_BUSY: if (!i_mul_done) w_next = S_WAIT_DONE;
      S_WAIT_DONE: if (i_mul_done)  w_next = S_RESP;
      S_RESP: begin
        o_resp_valid = 1'b1;
        if (i_resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
    end else if (w_accept) begin
      r_ptr <= w_ptr_nxt;
      r_id  <= w_idx;
      r_a   <= w_a;
      r_b   <= w_b;
      if (w_zero) r_result <= '0;
    end else if (r_state == S_WAIT_DONE && i_mul_done) begin
      r_result <= i_mul_result;
    end
  end

  assign o_req_ready        = w_gnt;
  assign o_resp_id          = r_id;
  assign o_resp_result      = r_result;
  assign o_mul_multiplier   = r_a;
  assign o_mul_multiplicand = r_b;

endmodule

// File: tb/tb_mul_scheduler.sv
// Directed bench for mul_scheduler with a 16-iteration start/done multiplier core model.
module tb_mul_scheduler;
  localparam int NREQ = 4, WIDTH = 32, IDW = 2;

  logic              clock = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid, req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic              resp_valid, resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [2*WIDTH-1:0] resp_result;
  logic              mul_start;
  logic [WIDTH-1:0]  mul_multiplier, mul_multiplicand;
  logic [2*WIDTH-1:0] mul_result;
  logic              mul_done;
  logic              busy;

  int errs = 0, checks = 0;

  always #5 clock = ~clock;

  mul_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_a(req_a), .i_req_b(req_b),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready),
    .o_resp_id(resp_id), .o_resp_result(resp_result),
    .o_mul_start(mul_start), .o_mul_multiplier(mul_multiplier),
    .o_mul_multiplicand(mul_multiplicand),
    .i_mul_result(mul_result), .i_mul_done(mul_done), .o_busy(busy)
  );

  // Core model: busy for 16 cycles after start, result valid when done rises.
  logic [WIDTH-1:0] ca, cb;
  int cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mul_done <= 1'b1; mul_result <= '0; cnt <= 0; ca <= '0; cb <= '0;
    end else if (mul_start) begin
      mul_done <= 1'b0; cnt <= 15; ca <= mul_multiplier; cb <= mul_multiplicand;
    end else if (!mul_done) begin
      if (cnt == 0) begin
        mul_done   <= 1'b1;
        mul_result <= {32'b0, ca} * {32'b0, cb};
      end else cnt <= cnt - 1;
    end
  end

  task automatic do_req(input int id, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int starts, output logic to);
    int w;
    to = 1'b0; lat = 0; starts = 0; w = 0;
    req_valid[id] = 1'b1;
    req_a[id*32 +: 32] = a;
    req_b[id*32 +: 32] = b;
    #1;
    while (!req_ready[id] && w < 50) begin @(negedge clock); w++; end
    if (w >= 50) begin to = 1'b1; req_valid[id] = 1'b0; return; end
    @(posedge clock); #1 req_valid[id] = 1'b0;
    @(negedge clock); if (mul_start) starts++;
    while (!resp_valid && lat < 100) begin
      @(negedge clock); lat++; if (mul_start) starts++;
    end
    if (lat >= 100) to = 1'b1;
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    @(posedge clock); #1 resp_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic wait_resp(input string nm);
    int w = 0;
    while (!resp_valid && w < 100) begin @(negedge clock); w++; end
    checks++;
    if (w >= 100) begin errs++; $display("FAIL %s timeout waiting for resp_valid", nm); end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    @(negedge clock);
    req_valid = 4'hF; #1;
    checks++; if (req_ready !== 4'b0) begin errs++; $display("FAIL rst_req_ready got=%b exp=0000", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errs++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++; if (resp_id !== 2'd0) begin errs++; $display("FAIL rst_resp_id got=%0d exp=0", resp_id); end
    checks++; if (resp_result !== 64'd0) begin errs++; $display("FAIL rst_resp_result got=%h exp=0", resp_result); end
    checks++; if (mul_start !== 1'b0) begin errs++; $display("FAIL rst_mul_start got=%b exp=0", mul_start); end
    checks++; if (busy !== 1'b0) begin errs++; $display("FAIL rst_busy got=%b exp=0", busy); end
    req_valid = '0;
    @(negedge clock); reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_single();
    int lat, st; logic to;
    do_req(0, 32'd35, 32'd17, lat, st, to);
    checks++; if (to) begin errs++; $display("FAIL single timeout"); end
    checks++; if (st != 1) begin errs++; $display("FAIL single_starts got=%0d exp=1", st); end
    checks++; if (lat + 1 != 19) begin errs++; $display("FAIL single_latency got=%0d exp=19", lat + 1); end
    checks++; if (resp_id !== 2'd0) begin errs++; $display("FAIL single_id got=%0d exp=0", resp_id); end
    checks++; if (resp_result !== 64'd595) begin errs++; $display("FAIL single_result got=%0d exp=595", resp_result); end
    finish_resp();
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errs++; $display("FAIL single_idle busy=%b resp_valid=%b exp=0/0", busy, resp_valid); end
  endtask

  task automatic test_max();
    int lat, st; logic to;
    do_req(3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, st, to);
    checks++; if (to) begin errs++; $display("FAIL max timeout"); end
    checks++; if (resp_id !== 2'd3) begin errs++; $display("FAIL max_id got=%0d exp=3", resp_id); end
    checks++; if (resp_result !== 64'hFFFF_FFFE_0000_0001) begin errs++; $display("FAIL max_result got=%h exp=fffffffe00000001", resp_result); end
    finish_resp();
  endtask

  task automatic test_round_robin();
    logic [63:0] exp_res [4];
    logic [3:0]  exp_g;
    int e, w;
    exp_res[0] = 64'd3549895;
    exp_res[1] = 64'd1000000;
    exp_res[2] = 64'h1_0000_0000;
    exp_res[3] = 64'd97406784;
    req_a = {32'd123456, 32'd65536, 32'd1000, 32'd31415};
    req_b = {32'd789,    32'd65536, 32'd1000, 32'd113};
    req_valid = 4'hF; #1;
    for (int g = 0; g < 5; g++) begin
      e = g % 4; exp_g = 4'b0001 << e; w = 0;
      while (!(|req_ready) && w < 50) begin @(negedge clock); w++; end
      checks++; if (req_ready !== exp_g) begin errs++; $display("FAIL rr_grant%0d got=%b exp=%b", g, req_ready, exp_g); end
      @(posedge clock); #1;
      wait_resp("rr");
      checks++; if (resp_id !== IDW'(e)) begin errs++; $display("FAIL rr_id%0d got=%0d exp=%0d", g, resp_id, e); end
      checks++; if (resp_result !== exp_res[e]) begin errs++; $display("FAIL rr_result%0d got=%0d exp=%0d", g, resp_result, exp_res[e]); end
      finish_resp();
    end
    req_valid = '0;
    @(negedge clock);
  endtask

  task automatic test_zero();
    int lat, st; logic to;
    do_req(0, 32'd0, 32'd7, lat, st, to);
    checks++; if (to) begin errs++; $display("FAIL zero timeout"); end
    checks++; if (resp_result !== 64'd0) begin errs++; $display("FAIL zero_result got=%0d exp=0", resp_result); end
`ifdef MUL_SCHED_ZERO_BYPASS_EN
    checks++; if (st != 0) begin errs++; $display("FAIL zero_starts got=%0d exp=0", st); end
    checks++; if (lat + 1 != 1) begin errs++; $display("FAIL zero_latency got=%0d exp=1", lat + 1); end
`else
    checks++; if (st != 1) begin errs++; $display("FAIL zero_starts got=%0d exp=1", st); end
    checks++; if (lat + 1 != 19) begin errs++; $display("FAIL zero_latency got=%0d exp=19", lat + 1); end
`endif
    finish_resp();
  endtask

  task automatic test_back_pressure();
    logic [IDW-1:0] id0; logic [63:0] res0; logic bad, rdy_bad; int w;
    req_a[1*32 +: 32] = 32'd12; req_b[1*32 +: 32] = 32'd12;
    req_a[2*32 +: 32] = 32'd5;  req_b[2*32 +: 32] = 32'd9;
    req_valid = 4'b0110; #1; w = 0;
    while (!(|req_ready) && w < 50) begin @(negedge clock); w++; end
    checks++; if (req_ready !== 4'b0010) begin errs++; $display("FAIL bp_grant got=%b exp=0010", req_ready); end
    @(posedge clock); #1 req_valid[1] = 1'b0;
    wait_resp("bp");
    checks++; if (resp_id !== 2'd1 || resp_result !== 64'd144) begin errs++; $display("FAIL bp_resp got id=%0d res=%0d exp id=1 res=144", resp_id, resp_result); end
    id0 = resp_id; res0 = resp_result; bad = 1'b0; rdy_bad = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (resp_valid !== 1'b1 || resp_id !== id0 || resp_result !== res0) bad = 1'b1;
      if (req_ready !== 4'b0) rdy_bad = 1'b1;
    end
    checks++; if (bad) begin errs++; $display("FAIL bp_stable got=changed exp=held id=%0d res=%0d", id0, res0); end
    checks++; if (rdy_bad) begin errs++; $display("FAIL bp_no_ready got=ready-asserted exp=0000"); end
    finish_resp();
    checks++; if (req_ready !== 4'b0100) begin errs++; $display("FAIL bp_next_grant got=%b exp=0100", req_ready); end
    @(posedge clock); #1 req_valid[2] = 1'b0;
    wait_resp("bp2");
    checks++; if (resp_id !== 2'd2 || resp_result !== 64'd45) begin errs++; $display("FAIL bp_resp2 got id=%0d res=%0d exp id=2 res=45", resp_id, resp_result); end
    finish_resp();
  endtask

  task automatic test_reset_mid();
    int w = 0;
    req_a[1*32 +: 32] = 32'd1000; req_b[1*32 +: 32] = 32'd3;
    req_valid = 4'b0010; #1;
    while (!(|req_ready) && w < 50) begin @(negedge clock); w++; end
    @(posedge clock); #1 req_valid = '0;
    repeat (5) @(negedge clock);
    checks++; if (busy !== 1'b1 || mul_done !== 1'b0) begin errs++; $display("FAIL mid_inflight busy=%b mul_done=%b exp=1/0", busy, mul_done); end
    reset = 1'b1; #1;
    checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || mul_start !== 1'b0) begin errs++; $display("FAIL mid_rst_ctrl busy=%b resp_valid=%b mul_start=%b exp=0/0/0", busy, resp_valid, mul_start); end
    checks++; if (resp_id !== 2'd0 || resp_result !== 64'd0) begin errs++; $display("FAIL mid_rst_resp id=%0d res=%0d exp=0/0", resp_id, resp_result); end
    checks++; if (mul_multiplier !== 32'd0 || mul_multiplicand !== 32'd0) begin errs++; $display("FAIL mid_rst_ops a=%0d b=%0d exp=0/0", mul_multiplier, mul_multiplicand); end
    @(negedge clock);
    reset = 1'b0;
    req_a[0*32 +: 32] = 32'd6; req_b[0*32 +: 32] = 32'd7;
    req_valid = 4'b1011; #1;
    checks++; if (req_ready !== 4'b0001) begin errs++; $display("FAIL mid_post_grant got=%b exp=0001", req_ready); end
    @(posedge clock); #1 req_valid = '0;
    wait_resp("mid");
    checks++; if (resp_id !== 2'd0 || resp_result !== 64'd42) begin errs++; $display("FAIL mid_post_resp got id=%0d res=%0d exp id=0 res=42", resp_id, resp_result); end
    finish_resp();
  endtask

  initial begin
    test_reset();
    test_single();
    test_max();
    test_round_robin();
    test_zero();
    test_back_pressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
